// File: rtl/rtc_time_set.sv
// Button-driven time-setting writer for the BCD RTC: captures the live time, edits hours/minutes/seconds, then strobes load.
// Optional digit blinking of the selected field is enabled by defining RTC_SET_BLINK_EN.
module rtc_time_set #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10,
  parameter int TIMEOUT_TICKS  = 1000
) (
  input  logic       hundred_clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hrm,
  input  logic [3:0] cur_hrl,
  input  logic [3:0] cur_minm,
  input  logic [3:0] cur_minl,
  input  logic [3:0] cur_secm,
  input  logic [3:0] cur_secl,
  output logic [3:0] set_hrm,
  output logic [3:0] set_hrl,
  output logic [3:0] set_minm,
  output logic [3:0] set_minl,
  output logic [3:0] set_secm,
  output logic [3:0] set_secl,
  output logic       load,
  output logic       editing,
  output logic [1:0] sel_field,
  output logic [5:0] blank_mask
);

  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [3:0]    DEB_MAX   = 4'(DEBOUNCE_TICKS);
  localparam logic [3:0]    DEB_PRE   = 4'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_PRE = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_PRE  = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TO_PRE    = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  state_t        state;
  logic [1:0]    mode_sync, inc_sync;
  logic [3:0]    mode_cnt, inc_cnt;
  logic          mode_evt, inc_evt;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [TW-1:0] to_cnt;
  logic          inc_held, rpt_hit;

  // Auto-repeat only runs once the debounced press has been reported and the button stays down.
  assign inc_held = inc_sync[1] && (inc_cnt == DEB_MAX);
  assign rpt_hit  = inc_held && (rpt_cnt == (rpt_first ? DELAY_PRE : RATE_PRE));

  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] >= 4'd3))
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_sixty(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || (v[7:4] == 4'd5 && v[3:0] == 4'd9))
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Synchronise, debounce and generate one-cycle button events (inc also auto-repeats).
  always_ff @(posedge hundred_clk or posedge rst) begin
    if (rst) begin
      mode_sync <= '0;
      inc_sync  <= '0;
      mode_cnt  <= '0;
      inc_cnt   <= '0;
      mode_evt  <= 1'b0;
      inc_evt   <= 1'b0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      mode_sync <= {mode_sync[0], btn_mode};
      inc_sync  <= {inc_sync[0], btn_inc};
      if (!mode_sync[1])
        mode_cnt <= '0;
      else if (mode_cnt != DEB_MAX)
        mode_cnt <= mode_cnt + 4'd1;
      if (!inc_sync[1])
        inc_cnt <= '0;
      else if (inc_cnt != DEB_MAX)
        inc_cnt <= inc_cnt + 4'd1;
      mode_evt <= mode_sync[1] && (mode_cnt == DEB_PRE);
      inc_evt  <= (inc_sync[1] && (inc_cnt == DEB_PRE)) || rpt_hit;
      if (!inc_held) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  // Edit FSM; mode takes priority over inc, and any event beats the idle timeout.
  always_ff @(posedge hundred_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      load      <= 1'b0;
      editing   <= 1'b0;
      sel_field <= 2'd0;
      to_cnt    <= '0;
      {set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl} <= '0;
    end else begin
      load <= 1'b0;
      if (editing && !(mode_evt || inc_evt) && to_cnt != TO_PRE)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
      case (state)
        IDLE: begin
          if (mode_evt) begin
            {set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl} <=
              {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl};
            state     <= EDIT_HR;
            editing   <= 1'b1;
            sel_field <= 2'd1;
          end
        end
        EDIT_HR, EDIT_MIN, EDIT_SEC: begin
          if (mode_evt) begin
            case (state)
              EDIT_HR: begin
                state     <= EDIT_MIN;
                sel_field <= 2'd2;
              end
              EDIT_MIN: begin
                state     <= EDIT_SEC;
                sel_field <= 2'd3;
              end
              default: begin
                state     <= COMMIT;
                load      <= 1'b1;
                editing   <= 1'b0;
                sel_field <= 2'd0;
              end
            endcase
          end else if (inc_evt) begin
            case (state)
              EDIT_HR:  {set_hrm, set_hrl}   <= inc_hours({set_hrm, set_hrl});
              EDIT_MIN: {set_minm, set_minl} <= inc_sixty({set_minm, set_minl});
              default:  {set_secm, set_secl} <= inc_sixty({set_secm, set_secl});
            endcase
          end else if (to_cnt == TO_PRE) begin
            state     <= IDLE;
            editing   <= 1'b0;
            sel_field <= 2'd0;
          end
        end
        COMMIT: state <= IDLE;
        default: begin
          state     <= IDLE;
          editing   <= 1'b0;
          sel_field <= 2'd0;
        end
      endcase
    end
  end

`ifdef RTC_SET_BLINK_EN
  logic [5:0] blink_cnt;

  // Restart the blink period on any event so an edited digit is shown straight away.
  always_ff @(posedge hundred_clk or posedge rst) begin
    if (rst)
      blink_cnt <= '0;
    else if (!editing || mode_evt || inc_evt || blink_cnt == 6'd49)
      blink_cnt <= '0;
    else
      blink_cnt <= blink_cnt + 6'd1;
  end

  always_comb begin
    blank_mask = 6'b000000;
    if (editing && blink_cnt >= 6'd25) begin
      case (sel_field)
        2'd1:    blank_mask = 6'b110000;
        2'd2:    blank_mask = 6'b001100;
        2'd3:    blank_mask = 6'b000011;
        default: blank_mask = 6'b000000;
      endcase
    end
  end
`else
  assign blank_mask = 6'b000000;
`endif

endmodule
